// File: rtl/pv_crosslayer_bank_if.sv
// Bus bundle for the PV+ interneuron bank: update strobe, pyramid activity in,
// PV+ states, inhibition outputs and status flags out.
interface pv_crosslayer_bank_if #(
  parameter int WIDTH = 18
);
  logic                    clk_en;
  logic signed [WIDTH-1:0] l23_x;
  logic signed [WIDTH-1:0] l4_x;
  logic signed [WIDTH-1:0] l5b_x;
  logic signed [WIDTH-1:0] pv_l23_state;
  logic signed [WIDTH-1:0] pv_l4_state;
  logic signed [WIDTH-1:0] pv_l5_state;
  logic signed [WIDTH-1:0] pv_l23_inhib;
  logic signed [WIDTH-1:0] pv_l4_inhib;
  logic signed [WIDTH-1:0] pv_l5_inhib;
  logic signed [WIDTH-1:0] pv_total_inhib;
  logic                    out_valid;
  logic                    overrun;

  modport master (
    output clk_en, l23_x, l4_x, l5b_x,
    input  pv_l23_state, pv_l4_state, pv_l5_state,
    input  pv_l23_inhib, pv_l4_inhib, pv_l5_inhib,
    input  pv_total_inhib, out_valid, overrun
  );

  modport slave (
    input  clk_en, l23_x, l4_x, l5b_x,
    output pv_l23_state, pv_l4_state, pv_l5_state,
    output pv_l23_inhib, pv_l4_inhib, pv_l5_inhib,
    output pv_total_inhib, out_valid, overrun
  );
endinterface

// File: rtl/pv_crosslayer_bank.sv
// Time-multiplexed PV+ bank: one shared leak integrator and one multiplier walk
// L2/3, L4 and L5 in turn, then form the weighted cross-layer inhibition total.
module pv_crosslayer_bank #(
  parameter int WIDTH     = 18,
  parameter int FRAC      = 14,
  parameter int TAU_SHIFT = 3,
  parameter int PV_GAIN   = 16384
) (
  input  logic                 clk,
  input  logic                 rst,
  pv_crosslayer_bank_if.slave  bus
);

  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]        GAIN  = WIDTH'(PV_GAIN);

  typedef enum logic [2:0] {IDLE, UPD_L23, UPD_L4, UPD_L5, SUM} fsm_t;

  fsm_t fsm_q, fsm_d;

  logic signed [WIDTH-1:0]   snap_l23, snap_l4, snap_l5;
  logic signed [WIDTH-1:0]   st_l23, st_l4, st_l5;
  logic signed [WIDTH-1:0]   inh_l23, inh_l4, inh_l5;
  logic signed [WIDTH-1:0]   total_q;
  logic                      out_valid_q;
  logic                      overrun_q;

  logic signed [WIDTH-1:0]   sel_x, sel_st;
  logic signed [WIDTH-1:0]   drive;
  logic signed [WIDTH:0]     diff, step;
  logic signed [WIDTH+1:0]   acc;
  logic signed [WIDTH-1:0]   st_new;
  logic [2*WIDTH-1:0]        prod, prod_sh;
  logic signed [WIDTH-1:0]   inh_new;
  logic [WIDTH+1:0]          sum_w;
  logic signed [WIDTH-1:0]   total_new;

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (bus.clk_en) fsm_d = UPD_L23;
      UPD_L23: fsm_d = UPD_L4;
      UPD_L4:  fsm_d = UPD_L5;
      UPD_L5:  fsm_d = SUM;
      SUM:     fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // The FSM state steers which layer's snapshot and state feed the shared datapath.
  always_comb begin
    sel_x  = snap_l23;
    sel_st = st_l23;
    case (fsm_q)
      UPD_L4: begin
        sel_x  = snap_l4;
        sel_st = st_l4;
      end
      UPD_L5: begin
        sel_x  = snap_l5;
        sel_st = st_l5;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (sel_x == S_MIN)    drive = S_MAX;
    else if (sel_x[WIDTH-1]) drive = -sel_x;
    else                   drive = sel_x;

    diff = $signed({drive[WIDTH-1], drive}) - $signed({sel_st[WIDTH-1], sel_st});
    step = diff >>> TAU_SHIFT;
    acc  = $signed({sel_st[WIDTH-1], sel_st[WIDTH-1], sel_st}) + $signed({step[WIDTH], step});

    if (acc[WIDTH+1])                st_new = '0;
    else if (|acc[WIDTH:WIDTH-1])    st_new = S_MAX;
    else                             st_new = acc[WIDTH-1:0];

    // State is non-negative after clamping, so the gain product is a plain unsigned multiply.
    prod    = {{WIDTH{1'b0}}, st_new} * {{WIDTH{1'b0}}, GAIN};
    prod_sh = prod >> FRAC;
    if (|prod_sh[2*WIDTH-1:WIDTH-1]) inh_new = S_MAX;
    else                             inh_new = prod_sh[WIDTH-1:0];

    sum_w = {2'b00, inh_l23} + {3'b000, inh_l4[WIDTH-1:1]} + {4'b0000, inh_l5[WIDTH-1:2]};
    if (|sum_w[WIDTH+1:WIDTH-1]) total_new = S_MAX;
    else                         total_new = sum_w[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_l23    <= '0;
      snap_l4     <= '0;
      snap_l5     <= '0;
      st_l23      <= '0;
      st_l4       <= '0;
      st_l5       <= '0;
      inh_l23     <= '0;
      inh_l4      <= '0;
      inh_l5      <= '0;
      total_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= (fsm_q == SUM);
      if (bus.clk_en && (fsm_q != IDLE)) overrun_q <= 1'b1;
      case (fsm_q)
        IDLE: begin
          if (bus.clk_en) begin
            snap_l23 <= bus.l23_x;
            snap_l4  <= bus.l4_x;
            snap_l5  <= bus.l5b_x;
          end
        end
        UPD_L23: begin
          st_l23  <= st_new;
          inh_l23 <= inh_new;
        end
        UPD_L4: begin
          st_l4   <= st_new;
          inh_l4  <= inh_new;
        end
        UPD_L5: begin
          st_l5   <= st_new;
          inh_l5  <= inh_new;
        end
        SUM:     total_q <= total_new;
        default: ;
      endcase
    end
  end

  assign bus.pv_l23_state   = st_l23;
  assign bus.pv_l4_state    = st_l4;
  assign bus.pv_l5_state    = st_l5;
  assign bus.pv_l23_inhib   = inh_l23;
  assign bus.pv_l4_inhib    = inh_l4;
  assign bus.pv_l5_inhib    = inh_l5;
  assign bus.pv_total_inhib = total_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_pv_crosslayer_bank.sv
// Bench for pv_crosslayer_bank: two instances (unity and double gain) driven in
// lockstep and checked against an arithmetic model of the PV+ update rules.
module tb_pv_crosslayer_bank;

  localparam int     W    = 18;
  localparam longint MAXV = 131071;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pv_crosslayer_bank_if #(.WIDTH(W)) bus_a ();
  pv_crosslayer_bank_if #(.WIDTH(W)) bus_b ();

  pv_crosslayer_bank #(.WIDTH(W), .FRAC(14), .TAU_SHIFT(3), .PV_GAIN(16384)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pv_crosslayer_bank #(.WIDTH(W), .FRAC(14), .TAU_SHIFT(3), .PV_GAIN(32768)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int     vectors     = 0;
  int     miscompares = 0;
  longint m_state[2][3];
  longint m_inh[2][3];
  longint m_total[2];
  longint gain[2]   = '{16384, 32768};
  string  lname[3]  = '{"l23", "l4", "l5"};

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [W-1:0] rnd18();
    return W'($urandom_range(0, 262143));
  endfunction

  // Floor division by 2^s written with ordinary integer division.
  function automatic longint floorShift(input longint v, input int s);
    longint d = longint'(1) << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic void modelReset();
    for (int g = 0; g < 2; g++) begin
      for (int l = 0; l < 3; l++) begin
        m_state[g][l] = 0;
        m_inh[g][l]   = 0;
      end
      m_total[g] = 0;
    end
  endfunction

  function automatic void modelUpdate(input longint x23, input longint x4, input longint x5);
    longint xs[3] = '{x23, x4, x5};
    for (int g = 0; g < 2; g++) begin
      for (int l = 0; l < 3; l++) begin
        longint drv = (xs[l] < 0) ? -xs[l] : xs[l];
        longint st;
        if (drv > MAXV) drv = MAXV;
        st = m_state[g][l] + floorShift(drv - m_state[g][l], 3);
        if (st < 0) st = 0;
        if (st > MAXV) st = MAXV;
        m_state[g][l] = st;
        m_inh[g][l]   = (st * gain[g]) / 16384;
        if (m_inh[g][l] > MAXV) m_inh[g][l] = MAXV;
      end
      m_total[g] = m_inh[g][0] + m_inh[g][1] / 2 + m_inh[g][2] / 4;
      if (m_total[g] > MAXV) m_total[g] = MAXV;
    end
  endfunction

  task automatic setInputs(input logic signed [W-1:0] x23, input logic signed [W-1:0] x4,
                           input logic signed [W-1:0] x5, input logic en);
    bus_a.l23_x = x23;  bus_a.l4_x = x4;  bus_a.l5b_x = x5;  bus_a.clk_en = en;
    bus_b.l23_x = x23;  bus_b.l4_x = x4;  bus_b.l5b_x = x5;  bus_b.clk_en = en;
  endtask

  task automatic compareAll(input string tag);
    longint obs[2][7];
    obs[0] = '{bus_a.pv_l23_state, bus_a.pv_l4_state, bus_a.pv_l5_state,
               bus_a.pv_l23_inhib, bus_a.pv_l4_inhib, bus_a.pv_l5_inhib, bus_a.pv_total_inhib};
    obs[1] = '{bus_b.pv_l23_state, bus_b.pv_l4_state, bus_b.pv_l5_state,
               bus_b.pv_l23_inhib, bus_b.pv_l4_inhib, bus_b.pv_l5_inhib, bus_b.pv_total_inhib};
    for (int g = 0; g < 2; g++) begin
      for (int l = 0; l < 3; l++) begin
        checkOutput($sformatf("%s_g%0d_%s_state", tag, g, lname[l]), obs[g][l], m_state[g][l]);
        checkOutput($sformatf("%s_g%0d_%s_inhib", tag, g, lname[l]), obs[g][3+l], m_inh[g][l]);
      end
      checkOutput($sformatf("%s_g%0d_total", tag, g), obs[g][6], m_total[g]);
    end
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // One strobe, scrambled inputs during the update, bounded wait for out_valid.
  task automatic applyStimulus(input logic signed [W-1:0] x23, input logic signed [W-1:0] x4,
                               input logic signed [W-1:0] x5, input int gap);
    int cnt;
    @(negedge clk);
    setInputs(x23, x4, x5, 1'b1);
    @(negedge clk);
    setInputs(rnd18(), rnd18(), rnd18(), 1'b0);
    cnt = 0;
    while (!bus_a.out_valid && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("latency", cnt, 4);
    checkOutput("valid_b", bus_b.out_valid, 1);
    modelUpdate(x23, x4, x5);
    compareAll("upd");
    @(negedge clk);
    checkOutput("valid_pulse", bus_a.out_valid, 0);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int ov_count;
    logic signed [W-1:0] xr[3];

    setInputs('0, '0, '0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      setInputs(18'sd5000, -18'sd7000, 18'sd9000, i[0]);
    end
    modelReset();
    compareAll("reset");
    checkOutput("reset_valid", bus_a.out_valid, 0);
    checkOutput("reset_overrun", bus_a.overrun, 0);
    setInputs('0, '0, '0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(18'sd0, 18'sd8192, 18'sd0, 2);
    checkOutput("single_l4_state", bus_a.pv_l4_state, 1024);
    checkOutput("single_l4_inhib", bus_a.pv_l4_inhib, 1024);
    checkOutput("single_total", bus_a.pv_total_inhib, 512);
    checkOutput("single_l4_inhib_g2", bus_b.pv_l4_inhib, 2048);
    applyStimulus(18'sd0, 18'sd8192, 18'sd0, 2);
    checkOutput("second_l4_state", bus_a.pv_l4_state, 1920);
    applyStimulus(18'sd0, 18'sd0, 18'sd0, 2);
    checkOutput("decay_l4_state", bus_a.pv_l4_state, 1680);

    // Reset lands on E2 while earlier results are still nonzero.
    @(negedge clk);
    setInputs(18'sd0, 18'sd8192, 18'sd0, 1'b1);
    @(negedge clk);
    setInputs(18'sd0, 18'sd8192, 18'sd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    modelReset();
    compareAll("midrst");
    rst = 1'b0;
    ov_count = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_a.out_valid) ov_count++;
    end
    checkOutput("midrst_no_valid", ov_count, 0);
    applyStimulus(18'sd0, 18'sd8192, 18'sd0, 2);
    checkOutput("midrst_redo_l4", bus_a.pv_l4_state, 1024);

    doReset(2);
    ov_count = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (bus_a.out_valid) ov_count++;
      setInputs(18'sd0, 18'sd8192, 18'sd0, (cyc == 0 || cyc == 1 || cyc == 4));
    end
    checkOutput("ovr_valid_count", ov_count, 1);
    modelUpdate(0, 8192, 0);
    compareAll("ovr");
    checkOutput("ovr_flag_a", bus_a.overrun, 1);
    checkOutput("ovr_flag_b", bus_b.overrun, 1);
    repeat (20) @(negedge clk);
    checkOutput("ovr_sticky", bus_a.overrun, 1);
    doReset(1);
    checkOutput("ovr_cleared", bus_a.overrun, 0);

    for (int i = 0; i < 100; i++) applyStimulus(-18'sd4096, 18'sd0, 18'sd0, 9);
    checkOutput("conv_range", (bus_a.pv_l23_state >= 4089 && bus_a.pv_l23_state <= 4096), 1);
    checkOutput("conv_total", bus_a.pv_total_inhib, m_state[0][0]);
    checkOutput("conv_overrun", bus_a.overrun, 0);

    doReset(2);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(-18'sd131072, -18'sd131072, -18'sd131072, 1);
      checkOutput("sat_nonneg", (bus_b.pv_l23_state >= 0 && bus_b.pv_l5_state >= 0), 1);
    end
    checkOutput("sat_inh_l23", bus_b.pv_l23_inhib, MAXV);
    checkOutput("sat_inh_l4", bus_b.pv_l4_inhib, MAXV);
    checkOutput("sat_inh_l5", bus_b.pv_l5_inhib, MAXV);
    checkOutput("sat_total", bus_b.pv_total_inhib, MAXV);

    doReset(2);
    for (int i = 0; i < 60; i++) begin
      for (int l = 0; l < 3; l++) begin
        case ($urandom_range(0, 5))
          0:       xr[l] = -18'sd131072;
          1:       xr[l] = 18'sd131071;
          default: xr[l] = rnd18();
        endcase
      end
      applyStimulus(xr[0], xr[1], xr[2], int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pv_crosslayer_bank.md
# pv_crosslayer_bank

Time-multiplexed PV+ interneuron bank that closes the loop on the cortical column's pyramidal outputs. It rectifies and leak-integrates L2/3, L4 and L5b pyramid activity into three PV+ states using one shared integrator and one multiplier. It then emits per-layer inhibition plus the cross-layer weighted total (1.0× L2/3 + 0.5× L4 + 0.25× L5). It sits between the column's pyramid outputs and the L2/3 inhibition input, updating once per `clk_en` tick.

## Interface
- `WIDTH`, 18, signed fixed-point width of all data ports
- `FRAC`, 14, fractional bits (1.0 = 16384)
- `TAU_SHIFT`, 3, leak shift; integration step = diff >>> TAU_SHIFT
- `PV_GAIN`, 16384, state-to-inhibition gain, Q(FRAC), unsigned, range 0..(2^WIDTH−1)
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `clk_en` in 1: update request strobe (one-cycle pulse)
- `l23_x`, `l4_x`, `l5b_x` in WIDTH signed: pyramid activity
- `pv_l23_state`, `pv_l4_state`, `pv_l5_state` out WIDTH signed: PV+ states, always in [0, 131071]
- `pv_l23_inhib`, `pv_l4_inhib`, `pv_l5_inhib` out WIDTH signed: per-layer inhibition
- `pv_total_inhib` out WIDTH signed: weighted sum
- `out_valid` out 1: one-cycle pulse when all outputs are refreshed
- `overrun` out 1: sticky; set when `clk_en` arrives while busy; cleared only by `rst`

## Operation
- FSM states: IDLE, UPD_L23, UPD_L4, UPD_L5, SUM.
- IDLE with `clk_en`=1: snapshot the three inputs into registers, then go to UPD_L23.
- IDLE with `clk_en`=0: stay in IDLE.
- UPD_L23 → UPD_L4 → UPD_L5 → SUM → IDLE, one cycle each and unconditional.
- `clk_en`=1 in any non-IDLE state is ignored (no re-snapshot) and sets `overrun`.
- Update step for each layer, using its snapshot:
  - drive = |x|; −2^(WIDTH−1) saturates to 2^(WIDTH−1)−1 = 131071.
  - diff = drive − state, computed at WIDTH+1 bits.
  - state += diff >>> TAU_SHIFT. This is an arithmetic shift, flooring toward −∞.
  - Clamp state to [0, 131071].
- Inhibition = (state_new × PV_GAIN) >>> FRAC.
  - Product is unsigned, 2·WIDTH bits.
  - Saturate the result to 131071.
  - Register it in the same cycle as state_new.
- SUM cycle: total = inh_l23 + (inh_l4 >>> 1) + (inh_l5 >>> 2).
  - Computed at WIDTH+2 bits, saturated to 131071.
  - `out_valid` = 1 for this single cycle.
- Only one multiplier instance exists; it is shared across the three UPD states.
- All outputs hold their values between updates.

## Timing
- Reset values: all states, inhibitions, total, snapshots = 0; `out_valid` = 0; `overrun` = 0; FSM = IDLE.
- Cycle numbering: edge E0 samples `clk_en`=1 in IDLE.
  - E1: `pv_l23_state` and `pv_l23_inhib` update.
  - E2: L4 state and inhibition update.
  - E3: L5 state and inhibition update.
  - E4: `pv_total_inhib` updates and `out_valid` = 1 until E5.
- Latency from `clk_en` to `out_valid` is 4 cycles. The earliest next accepted `clk_en` is sampled at E5.
- `clk_en` at E4 (FSM in SUM) is ignored and sets `overrun`.
- Inputs are sampled only at E0; changes during E1–E4 do not affect the current update.
- Reset mid-operation (`rst` at any edge):
  - Abort the update, return to IDLE, zero all outputs at that edge.
  - No `out_valid` is generated for the aborted update.
- `rst` and `clk_en` on the same edge: `rst` wins; no snapshot is taken.
- Outputs are intermediate between E1 and E4: the total reflects old per-layer values until E4. Consumers sample only on `out_valid`.

## Test plan
- Reset:
  - Stimulus: assert `rst` 10 cycles with nonzero inputs and `clk_en` pulsing.
  - Response: all outputs 0, `out_valid` 0, `overrun` 0.
- Single update, default parameters:
  - Stimulus: `l4_x`=8192, others 0, one `clk_en`.
  - Response: `out_valid` exactly 4 cycles later; `pv_l4_state`=1024, `pv_l4_inhib`=1024, `pv_total_inhib`=512, L2/3 and L5 = 0.
  - Second `clk_en` ≥5 cycles later: `pv_l4_state`=1920.
  - Next, set `l4_x`=0 and pulse `clk_en`: 1920 → 1680.
- Convergence:
  - Stimulus: `l23_x` = −4096 constant, 100 updates spaced 16 cycles apart.
  - Response: `pv_l23_state` in [4089, 4096]; `pv_total_inhib` = `pv_l23_inhib` = state.
  - Response: `overrun` stays 0.
- Saturation:
  - Stimulus: PV_GAIN=32768; all inputs = −131072; 200 updates.
  - Response: every state ≤ 131071 and never negative; every inhibition = 131071; total = 131071; no wrap at any step.
- Overrun:
  - Stimulus: `clk_en` high on 2 consecutive edges, then also at E4.
  - Response: only one `out_valid`; results equal the single-update case; `overrun`=1 and stays 1 until `rst`.
- Reset mid-operation:
  - Stimulus: `rst` at E2 of an update with `l4_x`=8192.
  - Response: all outputs 0 after that edge; no `out_valid`.
  - Next `clk_en` after reset reproduces the single-update results exactly.
